aes_input_stage: RTL and testbench

AES_INPUT_STAGE -- requirements
Module: aes_input_stage

---
 rtl/aes_pkg.sv | 18 +
 rtl/aes_word_packer.sv | 34 +++
 rtl/aes_input_stage.sv | 193 +++++++++++++++++++
 tb/tb_aes_input_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES input stage: block/word geometry,
// the first-round number and the input FSM state encoding.
package aes_pkg;

   localparam int AES_BLK_W  = 128;
   localparam int AES_WORD_W = 32;

   localparam logic [3:0] RND_FIRST = 4'd1;
   localparam logic [3:0] RND_NONE  = 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_KEY  = 2'd1,
      ST_DATA = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

endpackage

// File: rtl/aes_word_packer.sv
// Four-entry 32-bit word register loaded one word at a time by index.
// Word 0 lands in blk[0:31], word 3 in blk[96:127]; clr wipes all words.
module aes_word_packer
   import aes_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  load,
   input  logic [1:0]            idx,
   input  logic [0:AES_WORD_W-1] word,
   output logic [0:AES_BLK_W-1]  blk
);

   logic [0:AES_WORD_W-1] words_r [0:3];

   // Word storage: async clear on reset, synchronous clear or indexed load.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) begin
            words_r[i] <= '0;
         end
      end else if (clr) begin
         for (int i = 0; i < 4; i++) begin
            words_r[i] <= '0;
         end
      end else if (load) begin
         words_r[idx] <= word;
      end
   end

   assign blk = {words_r[0], words_r[1], words_r[2], words_r[3]};

endmodule

// File: rtl/aes_input_stage.sv
// AES input stage: collects a 4-word key and 4-word plaintext blocks,
// then presents round-0 state (plaintext XOR key) and the key to round 1.
// The key persists across any number of plaintext blocks.
module aes_input_stage
   import aes_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [0:AES_WORD_W-1] wordIn,
   input  logic                  wordValid,
   input  logic                  wordIsKey,
   output logic                  wordReady,
   output logic [0:AES_BLK_W-1]  rndDataOut,
   output logic [0:AES_BLK_W-1]  rndKeyOut,
   output logic [0:3]            rndNum,
   output logic                  outValid,
   input  logic                  outReady,
   output logic                  seqErr
);

   state_t                 state_r, state_s;
   logic [1:0]             cnt_r, cnt_s;
   logic                   key_loaded_r, key_loaded_s;
   logic                   seq_err_r;
   logic                   out_valid_r;
   logic [0:3]             rnd_num_r;
   logic [0:AES_BLK_W-1]   rnd_data_r, rnd_key_r;

   logic                   accept_s;
   logic                   set_err_s;
   logic                   key_load_s, key_clr_s;
   logic                   data_load_s, data_clr_s;
   logic                   fire_s, drain_s;
   logic [0:AES_BLK_W-1]   key_blk_s, data_blk_s, data_full_s;

   // Ready is held low throughout reset so nothing is accepted while the stage is cleared.
   assign wordReady = rst & (state_r != ST_HOLD);
   assign accept_s  = wordValid & wordReady;

   aes_word_packer u_key_packer (
      .clk  (clk),
      .rst  (rst),
      .clr  (key_clr_s),
      .load (key_load_s),
      .idx  (cnt_r),
      .word (wordIn),
      .blk  (key_blk_s)
   );

   aes_word_packer u_data_packer (
      .clk  (clk),
      .rst  (rst),
      .clr  (data_clr_s),
      .load (data_load_s),
      .idx  (cnt_r),
      .word (wordIn),
      .blk  (data_blk_s)
   );

   // Full plaintext on the completing edge: words 0..2 from storage, word 3 straight from the input.
   always_comb begin
      data_full_s          = data_blk_s;
      data_full_s[96:127]  = wordIn;
   end

   // Next-state and control decode for the word-collection FSM.
   always_comb begin
      state_s      = state_r;
      cnt_s        = cnt_r;
      key_loaded_s = key_loaded_r;
      set_err_s    = 1'b0;
      key_load_s   = 1'b0;
      key_clr_s    = 1'b0;
      data_load_s  = 1'b0;
      data_clr_s   = 1'b0;
      fire_s       = 1'b0;
      drain_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (wordIsKey) begin
                  key_load_s = 1'b1;
                  cnt_s      = 2'd1;
                  state_s    = ST_KEY;
               end else if (key_loaded_r) begin
                  data_load_s = 1'b1;
                  cnt_s       = 2'd1;
                  state_s     = ST_DATA;
               end else begin
                  set_err_s = 1'b1;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_KEY: begin
            if (accept_s) begin
               if (wordIsKey) begin
                  key_load_s = 1'b1;
                  if (cnt_r == 2'd3) begin
                     key_loaded_s = 1'b1;
                     cnt_s        = 2'd0;
                     state_s      = ST_IDLE;
                  end else begin
                     cnt_s = cnt_r + 2'd1;
                  end
               end else begin
                  set_err_s    = 1'b1;
                  key_clr_s    = 1'b1;
                  key_loaded_s = 1'b0;
                  cnt_s        = 2'd0;
                  state_s      = ST_IDLE;
               end
            end else begin
               state_s = ST_KEY;
            end
         end
         ST_DATA: begin
            if (accept_s) begin
               if (!wordIsKey) begin
                  data_load_s = 1'b1;
                  if (cnt_r == 2'd3) begin
                     fire_s  = 1'b1;
                     cnt_s   = 2'd0;
                     state_s = ST_HOLD;
                  end else begin
                     cnt_s = cnt_r + 2'd1;
                  end
               end else begin
                  set_err_s  = 1'b1;
                  data_clr_s = 1'b1;
                  cnt_s      = 2'd0;
                  state_s    = ST_IDLE;
               end
            end else begin
               state_s = ST_DATA;
            end
         end
         ST_HOLD: begin
            if (outReady) begin
               drain_s = 1'b1;
               state_s = ST_IDLE;
            end else begin
               state_s = ST_HOLD;
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = 2'd0;
         end
      endcase
   end

   // FSM state, word counter, key-present and sticky error flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= ST_IDLE;
         cnt_r        <= 2'd0;
         key_loaded_r <= 1'b0;
         seq_err_r    <= 1'b0;
      end else begin
         state_r      <= state_s;
         cnt_r        <= cnt_s;
         key_loaded_r <= key_loaded_s;
         seq_err_r    <= seq_err_r | set_err_s;
      end
   end

   // Round-1 output registers: loaded on block completion, valid/round cleared on hand-off.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_r <= 1'b0;
         rnd_num_r   <= RND_NONE;
         rnd_data_r  <= '0;
         rnd_key_r   <= '0;
      end else if (fire_s) begin
         out_valid_r <= 1'b1;
         rnd_num_r   <= RND_FIRST;
         rnd_data_r  <= data_full_s ^ key_blk_s;
         rnd_key_r   <= key_blk_s;
      end else if (drain_s) begin
         out_valid_r <= 1'b0;
         rnd_num_r   <= RND_NONE;
      end
   end

   assign outValid   = out_valid_r;
   assign rndNum     = rnd_num_r;
   assign rndDataOut = rnd_data_r;
   assign rndKeyOut  = rnd_key_r;
   assign seqErr     = seq_err_r;

endmodule

// File: tb/tb_aes_input_stage.sv
// Directed bench for aes_input_stage: a driver pushes expected round-1
// outputs into a scoreboard queue, a monitor pops them when outValid rises.
module tb_aes_input_stage;

   logic          clk = 1'b0;
   logic          rst;
   logic [0:31]   wordIn;
   logic          wordValid;
   logic          wordIsKey;
   logic          wordReady;
   logic [0:127]  rndDataOut;
   logic [0:127]  rndKeyOut;
   logic [0:3]    rndNum;
   logic          outValid;
   logic          outReady;
   logic          seqErr;

   localparam logic [0:127] KEY  = 128'h5468617473206D79204B756E67204675;
   localparam logic [0:127] P1   = 128'h54776F204F6E65204E696E652054776F;
   localparam logic [0:127] E1   = 128'h001F0E543C4E08596E221B0B4774311A;
   localparam logic [0:127] P2   = 128'h00000000000000000000000000000000;
   localparam logic [0:127] PF   = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF;
   localparam logic [0:127] EF   = 128'hAB979E8B8CDF9286DFB48A9198DFB98A;

   typedef struct {
      logic [0:127] data;
      logic [0:127] key;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   logic prev_valid = 1'b0;
   exp_t mon_e;

   aes_input_stage dut (
      .clk        (clk),
      .rst        (rst),
      .wordIn     (wordIn),
      .wordValid  (wordValid),
      .wordIsKey  (wordIsKey),
      .wordReady  (wordReady),
      .rndDataOut (rndDataOut),
      .rndKeyOut  (rndKeyOut),
      .rndNum     (rndNum),
      .outValid   (outValid),
      .outReady   (outReady),
      .seqErr     (seqErr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: each new output presentation is compared against the oldest expectation.
   always @(negedge clk) begin
      if (outValid && !prev_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_out", {127'd0, outValid}, 128'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("rndDataOut", rndDataOut, mon_e.data);
            chk("rndKeyOut", rndKeyOut, mon_e.key);
            chk("rndNum", {124'd0, rndNum}, 128'd1);
            chk("latency_cycle", cyc, mon_e.cyc);
         end
      end
      prev_valid <= outValid;
   end

   task automatic send_word(input logic [0:31] w, input logic k, input logic last,
                            input logic [0:127] ed, input logic [0:127] ek);
      int   n;
      exp_t e;
      @(negedge clk);
      wordIn    = w;
      wordIsKey = k;
      wordValid = 1'b1;
      n = 0;
      while (!wordReady && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!wordReady) begin
         chk("ready_timeout", {127'd0, wordReady}, 128'd1);
      end else if (last) begin
         e.data = ed;
         e.key  = ek;
         e.cyc  = cyc + 1;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      wordValid = 1'b0;
   endtask

   task automatic send_block(input logic [0:127] blk, input logic k, input int nwords,
                             input logic push, input logic [0:127] ed, input logic [0:127] ek);
      logic [0:127] b;
      b = blk;
      for (int i = 0; i < nwords; i++) begin
         send_word(b[32*i +: 32], k, push && (i == 3), ed, ek);
      end
   endtask

   task automatic apply_reset(input logic check_zero);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      if (check_zero) begin
         chk("rst_wordReady", {127'd0, wordReady}, 128'd0);
         chk("rst_outValid", {127'd0, outValid}, 128'd0);
         chk("rst_seqErr", {127'd0, seqErr}, 128'd0);
         chk("rst_rndNum", {124'd0, rndNum}, 128'd0);
         chk("rst_rndDataOut", rndDataOut, 128'd0);
         chk("rst_rndKeyOut", rndKeyOut, 128'd0);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("post_rst_wordReady", {127'd0, wordReady}, 128'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b0;
      wordIn    = 32'd0;
      wordValid = 1'b0;
      wordIsKey = 1'b0;
      outReady  = 1'b1;

      // Reset state, then a plaintext word with no key loaded is dropped.
      apply_reset(1'b1);
      send_word(32'h54776F20, 1'b0, 1'b0, P2, P2);
      @(negedge clk);
      chk("nokey_seqErr", {127'd0, seqErr}, 128'd1);
      chk("nokey_outValid", {127'd0, outValid}, 128'd0);

      // Fresh reset clears the sticky error; key then first plaintext.
      apply_reset(1'b1);
      send_block(KEY, 1'b1, 4, 1'b0, P2, P2);
      send_block(P1, 1'b0, 4, 1'b1, E1, KEY);
      repeat (3) @(negedge clk);
      chk("blk1_seqErr", {127'd0, seqErr}, 128'd0);

      // Second plaintext reuses the stored key.
      send_block(P2, 1'b0, 4, 1'b1, KEY, KEY);
      repeat (3) @(negedge clk);

      // Back-pressure: output held for 5 cycles, then drained.
      outReady = 1'b0;
      send_block(P1, 1'b0, 4, 1'b1, E1, KEY);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_outValid", {127'd0, outValid}, 128'd1);
         chk("hold_wordReady", {127'd0, wordReady}, 128'd0);
         chk("hold_rndDataOut", rndDataOut, E1);
         chk("hold_rndNum", {124'd0, rndNum}, 128'd1);
      end
      outReady = 1'b1;
      @(negedge clk);
      chk("drain_outValid", {127'd0, outValid}, 128'd0);
      chk("drain_rndNum", {124'd0, rndNum}, 128'd0);
      chk("drain_wordReady", {127'd0, wordReady}, 128'd1);
      chk("drain_rndDataOut_held", rndDataOut, E1);
      chk("drain_rndKeyOut_held", rndKeyOut, KEY);

      // Key word after two data words aborts the block; next full block still correct.
      send_block(PF, 1'b0, 2, 1'b0, P2, P2);
      send_word(32'h12345678, 1'b1, 1'b0, P2, P2);
      @(negedge clk);
      chk("abort_seqErr", {127'd0, seqErr}, 128'd1);
      chk("abort_outValid", {127'd0, outValid}, 128'd0);
      send_block(PF, 1'b0, 4, 1'b1, EF, KEY);
      repeat (3) @(negedge clk);

      // Reset after the third data word: everything cleared, key forgotten.
      send_block(P1, 1'b0, 3, 1'b0, P2, P2);
      apply_reset(1'b1);
      chk("rst2_seqErr_clear", {127'd0, seqErr}, 128'd0);
      send_word(32'h54776F20, 1'b0, 1'b0, P2, P2);
      @(negedge clk);
      chk("rst2_nokey_seqErr", {127'd0, seqErr}, 128'd1);
      repeat (4) @(negedge clk);
      chk("rst2_outValid", {127'd0, outValid}, 128'd0);

      chk("scoreboard_drained", sb.size(), 128'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
